// File: rtl/conv_pkg.sv
// Shared definitions for the convolution kernel scheduler: state encoding,
// width helpers and the position of the bias field in a weight-bank word.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT_W = 3'd2,
    S_CONV   = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Bias sits in the low bits of w_rd_data, weights above it.
  localparam int BIAS_LSB = 0;

  function automatic int weight_w(input int kw, input int kh, input int bw);
    return kw * kh * bw;
  endfunction

  function automatic int result_w(input int expand, input int rw, input int rh, input int bw);
    return 2 * expand * rw * rh * bw;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_sched_watchdog.sv
// Cycle counter that flags when the scheduler has sat in one waiting state
// for TIMEOUT_CYC cycles. Only instantiated when CONV_SCHED_TIMEOUT_EN is defined.
module conv_sched_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q is 0 in the first cycle of a state, so TIMEOUT_CYC-1 marks the last allowed cycle.
  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/conv_kernel_sched.sv
// Per-kernel sequencer for the conv engine: fetch weights, run the engine, store the result.
// Optional watchdog timeout enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_kernel_sched
  import conv_pkg::*;
#(
  parameter int NUM_KERNELS = 4,
  parameter int KERNEL_W    = 2,
  parameter int KERNEL_H    = 2,
  parameter int RES_W       = 3,
  parameter int RES_H       = 3,
  parameter int BITWIDTH    = 3,
  parameter int EXPAND      = 1,
  parameter int TIMEOUT_CYC = 64,
  localparam int WEIGHT_W   = weight_w(KERNEL_W, KERNEL_H, BITWIDTH),
  localparam int RESULT_W   = result_w(EXPAND, RES_W, RES_H, BITWIDTH),
  localparam int IDX_W      = idx_w(NUM_KERNELS)
) (
  input  logic                         clk_en,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         w_rd_en,
  output logic [IDX_W-1:0]             w_rd_addr,
  input  logic                         w_rd_valid,
  input  logic [WEIGHT_W+BITWIDTH-1:0] w_rd_data,
  output logic                         conv_en,
  output logic [WEIGHT_W-1:0]          weight,
  output logic [BITWIDTH-1:0]          bias,
  input  logic                         conv_fin,
  input  logic [RESULT_W-1:0]          conv_result,
  output logic                         res_wr_en,
  output logic [IDX_W-1:0]             res_wr_addr,
  output logic [RESULT_W-1:0]          res_wr_data,
  output logic                         err,
  output state_e                       dbg_state
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                first_q, first_d;
  logic                timeout;
  logic                busy_d, done_d, w_rd_en_d, conv_en_d, res_wr_en_d, err_d;
  logic [WEIGHT_W-1:0] weight_d;
  logic [BITWIDTH-1:0] bias_d;
  logic [RESULT_W-1:0] res_data_d;

  // State register; every output is registered alongside it.
  always_ff @(posedge clk_en) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      first_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      conv_en     <= 1'b0;
      weight      <= '0;
      bias        <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      busy        <= busy_d;
      done        <= done_d;
      w_rd_en     <= w_rd_en_d;
      w_rd_addr   <= idx_d;
      conv_en     <= conv_en_d;
      weight      <= weight_d;
      bias        <= bias_d;
      res_wr_en   <= res_wr_en_d;
      res_wr_addr <= idx_d;
      res_wr_data <= res_data_d;
      err         <= err_d;
    end
  end

  // Next-state logic; abort and timeout override every transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH:  state_d = S_WAIT_W;
      S_WAIT_W: if (w_rd_valid) state_d = S_CONV;
      S_CONV:   if (!first_q && conv_fin) state_d = S_STORE;
      S_STORE: begin
        if (idx_q == IDX_W'(NUM_KERNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    if (abort || timeout) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
  end

  // Output logic, decoded from the next state so the registers line up with it.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    w_rd_en_d   = (state_d == S_FETCH);
    conv_en_d   = (state_d == S_CONV);
    res_wr_en_d = (state_d == S_STORE);
    first_d     = (state_d == S_CONV) && (state_q != S_CONV);
    weight_d    = weight;
    bias_d      = bias;
    res_data_d  = res_wr_data;
    if (state_q == S_WAIT_W && state_d == S_CONV) begin
      weight_d = w_rd_data[WEIGHT_W+BITWIDTH-1:BITWIDTH];
      bias_d   = w_rd_data[BIAS_LSB +: BITWIDTH];
    end
    if (state_q == S_CONV && state_d == S_STORE) begin
      res_data_d = conv_result;
    end
    err_d = err | timeout;
  end

`ifdef CONV_SCHED_TIMEOUT_EN
  logic wd_clear, wd_run;

  assign wd_run   = (state_q == S_WAIT_W) || (state_q == S_CONV);
  assign wd_clear = (state_d != state_q) && ((state_d == S_WAIT_W) || (state_d == S_CONV));

  conv_sched_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (clk_en),
    .rst_i    (rst),
    .clear_i  (wd_clear),
    .run_i    (wd_run),
    .expired_o(timeout)
  );
`else
  // No watchdog: the scheduler waits indefinitely and err stays 0.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_kernel_sched.sv
// Directed self-checking bench for conv_kernel_sched with a weight-bank responder
// and a small convolution engine model on a fixed 4x4 image.
module tb_conv_kernel_sched;
  import conv_pkg::*;

  localparam int WEIGHT_W = 12;
  localparam int BITW     = 3;
  localparam int RESULT_W = 54;
  localparam int IDX_W    = 2;
  localparam int IMG [16] = '{3, 2, 4, 1, 2, 0, 6, 2, 6, 7, 1, 2, 5, 6, 4, 2};
  localparam int K0_EXP [9] = '{4, 9, 7, 10, 2, 9, 13, 12, 4};

  logic                       clk_en = 1'b0;
  logic                       rst, start, abort;
  logic                       busy, done, w_rd_en, w_rd_valid, conv_en, conv_fin;
  logic                       res_wr_en, err;
  logic [IDX_W-1:0]           w_rd_addr, res_wr_addr;
  logic [WEIGHT_W+BITW-1:0]   w_rd_data;
  logic [WEIGHT_W-1:0]        weight;
  logic [BITW-1:0]            bias;
  logic [RESULT_W-1:0]        conv_result, res_wr_data;
  state_e                     dbg_state;

  conv_kernel_sched dut (
    .clk_en(clk_en), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_valid(w_rd_valid), .w_rd_data(w_rd_data),
    .conv_en(conv_en), .weight(weight), .bias(bias),
    .conv_fin(conv_fin), .conv_result(conv_result),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / global bound
  always #5 clk_en = ~clk_en;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required finish earlier");
    $fatal(1, "bench did not finish");
  end

  // ---------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- models
  logic [WEIGHT_W+BITW-1:0] bank [4];

  function automatic logic [RESULT_W-1:0] conv_model(input logic [WEIGHT_W+BITW-1:0] word);
    logic [RESULT_W-1:0] r;
    logic [5:0]          s;
    r = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        s = 6'(word[2:0]);
        for (int kr = 0; kr < 2; kr++) begin
          for (int kc = 0; kc < 2; kc++) begin
            s = s + 6'(int'(word[3 + 3*(kr*2+kc) +: 3]) * IMG[(rr+kr)*4 + cc + kc]);
          end
        end
        r[6*(rr*3+cc) +: 6] = s;
      end
    end
    return r;
  endfunction

  int       bank_delay = 1;
  int       bcnt = 0;
  logic [1:0] baddr = '0;

  initial begin
    w_rd_valid = 1'b0;
    w_rd_data  = '0;
    forever begin
      @(negedge clk_en);
      w_rd_valid = 1'b0;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          w_rd_valid = 1'b1;
          w_rd_data  = bank[baddr];
        end
      end
      if (w_rd_en) begin
        bcnt  = bank_delay;
        baddr = w_rd_addr;
      end
    end
  end

  int fin_delay = 3;
  bit fin_never = 1'b0;
  bit force_fin = 1'b0;
  int en_cnt    = 0;

  initial begin
    conv_fin    = 1'b0;
    conv_result = '0;
    forever begin
      @(negedge clk_en);
      if (conv_en) en_cnt++; else en_cnt = 0;
      conv_fin    = (force_fin && en_cnt <= 1) || (!fin_never && conv_en && en_cnt >= fin_delay);
      conv_result = conv_model({weight, bias});
    end
  end

  // ---------------- monitor / scoreboard
  logic [RESULT_W-1:0]      exp_q [$];
  logic [IDX_W-1:0]         obs_addr [$];
  logic [RESULT_W-1:0]      obs_data [$];
  logic [WEIGHT_W+BITW-1:0] obs_wb [$];
  int                       obs_len [$];
  int                       gap_q [$];
  int done_cnt, conv_cyc, gap_cnt, busy_cyc;
  bit gap_run;

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_wb.delete(); obs_len.delete(); gap_q.delete();
    exp_q.delete();
    done_cnt = 0; conv_cyc = 0; gap_cnt = 0; gap_run = 0; busy_cyc = 0;
  endtask

  initial begin
    clear_obs();
    forever begin
      @(negedge clk_en);
      if (busy) busy_cyc++;
      if (conv_en) conv_cyc++;
      if (res_wr_en) begin
        obs_addr.push_back(res_wr_addr);
        obs_data.push_back(res_wr_data);
        obs_wb.push_back({weight, bias});
        obs_len.push_back(conv_cyc);
        conv_cyc = 0;
      end
      if (done) done_cnt++;
      if (gap_run) begin
        gap_cnt++;
        if (conv_en) begin
          gap_run = 1'b0;
          gap_q.push_back(gap_cnt);
        end
      end
      if (w_rd_en) begin
        gap_run = 1'b1;
        gap_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks
  task automatic run_layer(input int max_cyc, output bit ok);
    @(negedge clk_en); #1;
    start = 1'b1;
    @(negedge clk_en); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_en); #1;
    end
  endtask

  task automatic check_full_run(input string tag, input int exp_len, input int exp_busy);
    check_eq({tag, "_nwr"}, obs_addr.size(), 4);
    check_eq({tag, "_done"}, done_cnt, 1);
    check_eq({tag, "_busy_cyc"}, busy_cyc, exp_busy);
    for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
      check_eq($sformatf("%s_addr%0d", tag, k), obs_addr[k], k);
      check_eq($sformatf("%s_wb%0d", tag, k), obs_wb[k], bank[k]);
      check_eq($sformatf("%s_len%0d", tag, k), obs_len[k], exp_len);
      if (exp_q.size() > 0) check_eq($sformatf("%s_data%0d", tag, k), obs_data[k], exp_q.pop_front());
    end
  endtask

  // ---------------- main sequence
  bit ok;
  logic [RESULT_W-1:0] k0_exp;

  initial begin
    bank[0] = 15'b001_000_000_001_001;
    bank[1] = 15'b010_001_011_000_010;
    bank[2] = 15'b111_111_111_111_111;
    bank[3] = 15'b000_100_000_011_101;
    k0_exp = '0;
    for (int e = 0; e < 9; e++) k0_exp[6*e +: 6] = 6'(K0_EXP[e]);

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk_en);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outs", {done, w_rd_en, conv_en, res_wr_en, err}, 0);
    check_eq("rst_wb", {weight, bias}, 0);
    check_eq("rst_res_data", res_wr_data, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;

    // basic run and data path
    clear_obs();
    bank_delay = 1; fin_delay = 3;
    exp_q.push_back(k0_exp);
    for (int k = 1; k < 4; k++) exp_q.push_back(conv_model(bank[k]));
    run_layer(200, ok);
    check_eq("basic_finish", ok, 1);
    check_full_run("basic", 3, 4*6 + 1);
    if (obs_data.size() > 0) check_eq("basic_elem0", obs_data[0][5:0], 4);
    if (gap_q.size() > 0) check_eq("basic_gap", gap_q[0], 2);
    check_eq("basic_idle_busy", busy, 0);

    // stale fin held high through WAIT_W and the first CONV cycle
    clear_obs();
    force_fin = 1'b1; fin_delay = 4;
    run_layer(200, ok);
    force_fin = 1'b0; fin_delay = 3;
    check_eq("stale_finish", ok, 1);
    check_full_run("stale", 4, 4*7 + 1);

    // weight-bank stall
    clear_obs();
    bank_delay = 10;
    run_layer(300, ok);
    bank_delay = 1;
    check_eq("stall_finish", ok, 1);
    check_full_run("stall", 3, 4*15 + 1);
    for (int k = 0; k < gap_q.size(); k++) check_eq($sformatf("stall_gap%0d", k), gap_q[k], 11);

    // abort in CONV of kernel 2
    clear_obs();
    @(negedge clk_en); #1;
    start = 1'b1;
    @(negedge clk_en); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (obs_addr.size() == 2 && conv_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_en); #1;
    end
    check_eq("abort_reach_k2", ok, 1);
    abort = 1'b1;
    @(negedge clk_en); #1;
    abort = 1'b0;
    check_eq("abort_conv_en", conv_en, 0);
    check_eq("abort_busy", busy, 0);
    repeat (20) @(negedge clk_en);
    #1;
    check_eq("abort_nwr", obs_addr.size(), 2);
    check_eq("abort_done", done_cnt, 0);

    // abort wins over a simultaneous start
    start = 1'b1; abort = 1'b1;
    @(negedge clk_en); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", busy, 0);
    check_eq("abort_start_fetch", w_rd_en, 0);

    // restart after abort runs from kernel 0
    clear_obs();
    run_layer(200, ok);
    check_eq("restart_finish", ok, 1);
    check_full_run("restart", 3, 4*6 + 1);
    check_eq("err_low", err, 0);

`ifdef CONV_SCHED_TIMEOUT_EN
    clear_obs();
    fin_never = 1'b1;
    run_layer(300, ok);
    check_eq("to_finish", ok, 1);
    check_eq("to_err", err, 1);
    check_eq("to_state", dbg_state, S_IDLE);
    check_eq("to_conv_cyc", conv_cyc, 64);
    check_eq("to_no_done", done_cnt, 0);
    check_eq("to_no_write", obs_addr.size(), 0);
    repeat (5) @(negedge clk_en);
    #1;
    check_eq("to_err_sticky", err, 1);
    fin_never = 1'b0;
    rst = 1'b1;
    @(negedge clk_en); #1;
    rst = 1'b0;
    check_eq("to_err_rst", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_kernel_sched.md
Name: conv_kernel_sched

Overview:
- Sequencer for the single conv_top engine.
- Runs one convolution per kernel (output channel), NUM_KERNELS kernels in total, over the same input image.
- For each kernel it:
  - fetches the kernel's weights and bias from the weight bank,
  - drives conv_en and waits for conv_fin,
  - writes the flattened result to the feature-map buffer.
- Sits between the layer controller (start/done) and the conv engine, weight bank and result buffer.

Parameters:
- NUM_KERNELS, 4, number of kernels run per layer.
- KERNEL_W, 2, kernel width.
- KERNEL_H, 2, kernel height.
- RES_W, 3, result map width, equal to (IMG_W-KERNEL_W+2*PAD)/STRIDE+1.
- RES_H, 3, result map height.
- BITWIDTH, 3, element width.
- EXPAND, 1, result widening factor.
- TIMEOUT_CYC, 64, cycle limit for the watchdog in the optional feature.
- Derived localparams:
  - WEIGHT_W = KERNEL_W*KERNEL_H*BITWIDTH
  - RESULT_W = 2*EXPAND*RES_W*RES_H*BITWIDTH
  - IDX_W = $clog2(NUM_KERNELS), minimum 1

Ports:
- clk_en  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle layer start request; accepted only in IDLE.
- abort  in  1  synchronous abort.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last kernel's result is stored.
- w_rd_en  out  1  one-cycle weight-bank read strobe.
- w_rd_addr  out  IDX_W  kernel index to read.
- w_rd_valid  in  1  weight-bank data valid.
- w_rd_data  in  WEIGHT_W+BITWIDTH  {weights, bias}; bias is in bits [BITWIDTH-1:0].
- conv_en  out  1  engine enable, level-held.
- weight  out  WEIGHT_W  registered weights to the engine.
- bias  out  BITWIDTH  registered bias to the engine.
- conv_fin  in  1  engine completion.
- conv_result  in  RESULT_W  engine result.
- res_wr_en  out  1  one-cycle result write strobe.
- res_wr_addr  out  IDX_W  result slot, equal to the kernel index.
- res_wr_data  out  RESULT_W  registered copy of conv_result.
- err  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst=1 at a clk_en edge):
  - state=IDLE, idx=0.
  - All outputs 0: busy, done, w_rd_en, conv_en, res_wr_en, weight, bias, res_wr_data, err.
- All outputs are registered.
- IDLE:
  - start=1 -> FETCH with idx=0.
  - start in any other state is ignored.
- FETCH:
  - w_rd_en=1 for exactly one cycle, w_rd_addr=idx.
  - Next state WAIT_W.
- WAIT_W:
  - Wait any number of cycles for w_rd_valid.
  - On w_rd_valid, latch weight and bias -> CONV.
  - weight and bias are stable from before conv_en rises until the next FETCH completes.
- CONV:
  - conv_en=1 continuously.
  - conv_fin is ignored in the first CONV cycle, so a stale fin from the previous kernel is never accepted.
  - From the second CONV cycle on, conv_fin=1 -> latch conv_result -> STORE; conv_en is 0 in STORE.
- STORE:
  - res_wr_en=1 for one cycle, res_wr_addr=idx.
  - idx==NUM_KERNELS-1 -> DONE; otherwise idx+1 -> FETCH.
- DONE:
  - done=1 for one cycle -> IDLE, idx=0.
- Latency for one kernel, with valid and fin returning immediately:
  - FETCH 1 + WAIT_W 1 + CONV (at least 2 + engine time) + STORE 1.
- abort=1 in any state:
  - Next cycle: IDLE, idx=0, conv_en=0, no done, no further res_wr_en.
  - Results already written stay in the buffer.
  - abort and start in the same cycle: abort wins.
- rst mid-operation behaves the same as abort, but also clears err.
- Boundary cases:
  - NUM_KERNELS=1: STORE goes directly to DONE.
  - idx never wraps during a run.
  - w_rd_valid outside WAIT_W is ignored.
  - conv_fin outside CONV is ignored.

Optional Feature:
- Macro: CONV_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_W and CONV and clears on entry to each of those states.
  - Reaching TIMEOUT_CYC cycles sets err=1 (sticky until rst) and forces IDLE with conv_en=0 and no done.
- Undefined:
  - No counter; err is constant 0.
  - The scheduler waits indefinitely.

Decomposition:
- Shared package conv_pkg holds:
  - state encoding: IDLE, FETCH, WAIT_W, CONV, STORE, DONE
  - WEIGHT_W and RESULT_W width functions
  - the bias slice position in w_rd_data
- Natural sub-module: conv_sched_watchdog, the timeout counter, instantiated only under the macro.

Test Plan:
1. Basic run, NUM_KERNELS=4; bank returns valid 1 cycle after strobe; engine model asserts fin 3 cycles after conv_en -> four res_wr_en pulses at addr 0,1,2,3, then one done pulse; busy falls with IDLE.
2. Data path: kernel 0 word = weights 12'b001_000_000_001, bias 3'b001, on the 4x4 image 3 2 4 1 / 2 0 6 2 / 6 7 1 2 / 5 6 4 2 -> weight/bias outputs match the word; res_wr_data[addr 0] equals the engine output, first element 4.
3. Stale fin: conv_fin held high into the first CONV cycle -> not accepted; STORE occurs only after fin is seen in a later cycle.
4. Stall: w_rd_valid delayed 10 cycles -> conv_en stays 0 until the cycle after valid.
5. Abort in CONV of kernel 2 -> conv_en=0 next cycle, no done, no write at addr 2; a new start runs from idx 0.
6. With CONV_SCHED_TIMEOUT_EN and TIMEOUT_CYC=64, engine never asserts fin -> err=1 after 64 CONV cycles, state IDLE, err held until rst.
